// File: rtl/imm_ext_if.sv
// Operand/result bundle between the control/datapath side and imm_ext_unit.
// Valid-only handshake: in_valid marks ImmInput/ImmSrc as a request this cycle; there is no ready (never stalls). out_valid pulses one cycle after each accepted request.
interface imm_ext_if;
  logic [24:0] ImmInput;
  logic [2:0]  ImmSrc;
  logic        in_valid;
  logic [31:0] ImmExt;
  logic        out_valid;
  logic        illegal;

  modport master (
    output ImmInput, ImmSrc, in_valid,
    input  ImmExt, out_valid, illegal
  );

  modport slave (
    input  ImmInput, ImmSrc, in_valid,
    output ImmExt, out_valid, illegal
  );
endinterface

// File: rtl/imm_ext_unit.sv
// RV32 immediate generator with a registered output (1-cycle latency).
// Optional macro IMMUNIT_CSR_UIMM_EN: ImmSrc=011 selects the CSR uimm (Z) format.
module imm_ext_unit #(
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst,
  imm_ext_if.slave bus
);

  logic [31:0] immNext;
  logic        illegalNext;
  logic [24:0] in;

  assign in = bus.ImmInput;

  // In[24] is instr[31]; it is the sign bit for every sign-extended format.
  always_comb begin
    immNext     = 32'h0000_0000;
    illegalNext = 1'b0;
    case (bus.ImmSrc)
      3'b000: immNext = {{20{in[24]}}, in[24:13]};
      3'b001: immNext = {{20{in[24]}}, in[24:18], in[4:0]};
      3'b101: immNext = {{19{in[24]}}, in[24], in[0], in[23:18], in[4:1], 1'b0};
      3'b010: immNext = {in[24:5], 12'h000};
      3'b110: immNext = {{11{in[24]}}, in[24], in[12:5], in[13], in[23:14], 1'b0};
`ifdef IMMUNIT_CSR_UIMM_EN
      3'b011: immNext = {27'b0, in[12:8]};
`endif
      default: begin
        immNext     = 32'h0000_0000;
        illegalNext = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ImmExt    <= RST_VAL;
      bus.out_valid <= 1'b0;
      bus.illegal   <= 1'b0;
    end else if (bus.in_valid) begin
      bus.ImmExt    <= immNext;
      bus.out_valid <= 1'b1;
      bus.illegal   <= illegalNext;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_ext_unit.sv
// Self-checking bench for imm_ext_unit: directed test-plan steps, then random
// traffic checked against an instruction-level RISC-V immediate model.
module tb_imm_ext_unit;
  localparam logic [31:0] RST_VAL = 32'h0000_0000;

  logic clk;
  logic rst;
  imm_ext_if bus ();

  imm_ext_unit #(.RST_VAL(RST_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {ImmExt, out_valid, illegal}
  logic [33:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_imm = RST_VAL;
  logic        m_ill = 1'b0;
  logic        m_ov  = 1'b0;

  // Reference model works on the full instruction word as the ISA manual lays it out.
  function automatic logic [32:0] ref_imm(input logic [24:0] in, input logic [2:0] src);
    logic [31:0]        instr;
    logic signed [31:0] s;
    instr = {in, 7'b0};
    s     = instr;
    case (src)
      3'b000: ref_imm = {1'b0, 32'(s >>> 20)};
      3'b001: ref_imm = {1'b0, 32'((s >>> 25) << 5) | 32'(instr[11:7])};
      3'b101: ref_imm = {1'b0, 32'((s >>> 31) << 12) | (32'(instr[7]) << 11)
                               | (32'(instr[30:25]) << 5) | (32'(instr[11:8]) << 1)};
      3'b010: ref_imm = {1'b0, instr & 32'hFFFF_F000};
      3'b110: ref_imm = {1'b0, 32'((s >>> 31) << 20) | (32'(instr[19:12]) << 12)
                               | (32'(instr[20]) << 11) | (32'(instr[30:21]) << 1)};
`ifdef IMMUNIT_CSR_UIMM_EN
      3'b011: ref_imm = {1'b0, 32'(instr[19:15])};
`endif
      default: ref_imm = {1'b1, 32'h0};
    endcase
  endfunction

  task automatic check_field(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs on negedge, sample #1 after the following posedge
  task automatic step(input logic r, input logic [24:0] in, input logic [2:0] src, input logic v);
    logic [32:0] res;
    logic [33:0] exp;
    @(negedge clk);
    rst          = r;
    bus.ImmInput = in;
    bus.ImmSrc   = src;
    bus.in_valid = v;
    if (r) begin
      m_imm = RST_VAL; m_ill = 1'b0; m_ov = 1'b0;
    end else if (v) begin
      res   = ref_imm(in, src);
      m_imm = res[31:0]; m_ill = res[32]; m_ov = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
    exp_q.push_back({m_imm, m_ov, m_ill});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check_field("imm",       bus.ImmExt,           exp[33:2]);
    check_field("out_valid", 32'(bus.out_valid),   32'(exp[1]));
    check_field("illegal",   32'(bus.illegal),     32'(exp[0]));
  endtask

  task automatic check_const(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_field(tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.ImmInput = '0;
    bus.ImmSrc   = '0;
    bus.in_valid = 1'b0;

    // reset state
    step(1'b1, 25'h0, 3'b000, 1'b0);

    // directed test-plan steps with hand-computed values
    step(1'b0, 25'b0000000011110000000000000, 3'b000, 1'b1);
    check_const("plan_I", bus.ImmExt, 32'h0000_000F);
    step(1'b0, 25'b1000000000000000000000010, 3'b001, 1'b1);
    check_const("plan_S", bus.ImmExt, 32'hFFFF_F802);
    step(1'b0, 25'b0000001000000000000000010, 3'b101, 1'b1);
    check_const("plan_B", bus.ImmExt, 32'h0000_0022);
    step(1'b0, 25'b0000000000000000000100000, 3'b010, 1'b1);
    check_const("plan_U", bus.ImmExt, 32'h0000_1000);
    step(1'b0, 25'b0000000000000000000100000, 3'b110, 1'b1);
    check_const("plan_J", bus.ImmExt, 32'h0000_1000);
    step(1'b0, 25'h1FF_FFFF, 3'b111, 1'b1);
    check_const("plan_ill_imm", bus.ImmExt, 32'h0);
    check_const("plan_ill_flag", 32'(bus.illegal), 32'd1);
    step(1'b0, 25'h0AB_CDEF, 3'b000, 1'b0);
    check_const("plan_hold_flag", 32'(bus.illegal), 32'd1);
    step(1'b0, 25'h1FF_FFFF, 3'b100, 1'b1);
    step(1'b0, 25'b0000000000001010100000000, 3'b011, 1'b1);
`ifdef IMMUNIT_CSR_UIMM_EN
    check_const("plan_Z", bus.ImmExt, 32'h0000_0015);
`else
    check_const("plan_011_ill", 32'(bus.illegal), 32'd1);
`endif
    // boundary: all-ones / sign bit extremes
    step(1'b0, 25'h1FF_FFFF, 3'b000, 1'b1);
    step(1'b0, 25'h1FF_FFFF, 3'b110, 1'b1);
    step(1'b0, 25'h100_0000, 3'b101, 1'b1);

    // reset mid-stream wins over in_valid, then results resume
    step(1'b0, 25'h123_4567, 3'b010, 1'b1);
    step(1'b1, 25'h1FF_FFFF, 3'b000, 1'b1);
    step(1'b0, 25'h0F0_F0F0, 3'b001, 1'b1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 29) == 0), 25'($urandom), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
